// File: rtl/hwag_channel_scheduler.sv
// Angle-driven channel output scheduler.
// Host writes land in shadow registers and are copied to the active set/reset
// angles once per revolution (or continuously while the angle generator is not
// synchronised). After every angle step, one shared equality comparator walks
// the channels round-robin, one channel per clock.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | angle generator not synchronised; outputs low, ticks ignored
// ST_SCAN | synchronised; each angle_tick starts a scan over all channels
module hwag_channel_scheduler #(
    parameter int CH_NUM      = 4,
    parameter int ANGLE_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hwag_start,
    input  logic [ANGLE_WIDTH-1:0] angle,
    input  logic                   angle_tick,
    input  logic                   rev_strobe,
    input  logic                   wr_en,
    input  logic [$clog2(CH_NUM):0] wr_addr,
    input  logic [ANGLE_WIDTH-1:0] wr_data,
    input  logic [CH_NUM-1:0]      ch_ena,
    input  logic                   ovr_clr,
    output logic [CH_NUM-1:0]      ch_out,
    output logic                   scan_busy,
    output logic                   overrun
);

    localparam int CH_AW = $clog2(CH_NUM);
    localparam logic [CH_AW-1:0] LAST_IDX = CH_AW'(CH_NUM - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t                 state_q, state_d;
    logic [ANGLE_WIDTH-1:0] sh_set_q  [CH_NUM];
    logic [ANGLE_WIDTH-1:0] sh_set_d  [CH_NUM];
    logic [ANGLE_WIDTH-1:0] sh_rst_q  [CH_NUM];
    logic [ANGLE_WIDTH-1:0] sh_rst_d  [CH_NUM];
    logic [ANGLE_WIDTH-1:0] act_set_q [CH_NUM];
    logic [ANGLE_WIDTH-1:0] act_set_d [CH_NUM];
    logic [ANGLE_WIDTH-1:0] act_rst_q [CH_NUM];
    logic [ANGLE_WIDTH-1:0] act_rst_d [CH_NUM];
    logic [ANGLE_WIDTH-1:0] angle_q, angle_d;
    logic [CH_NUM-1:0]      pending_q, pending_d;
    logic [CH_NUM-1:0]      ch_out_q, ch_out_d;
    logic [CH_AW-1:0]       idx_q, idx_d;
    logic                   overrun_q, overrun_d;
    logic                   ovr_set;
    logic [CH_AW-1:0]       wr_ch;
    logic                   wr_sel;

    assign wr_ch  = wr_addr[CH_AW:1];
    assign wr_sel = wr_addr[0];

    // Shadow writes and commit of shadow into the active angle registers.
    always_comb begin
        sh_set_d  = sh_set_q;
        sh_rst_d  = sh_rst_q;
        act_set_d = act_set_q;
        act_rst_d = act_rst_q;
        // Commit reads the registered shadow, so a write in the same cycle
        // waits for the following revolution.
        if (!hwag_start || rev_strobe) begin
            act_set_d = sh_set_q;
            act_rst_d = sh_rst_q;
        end
        if (wr_en && (int'(wr_ch) < CH_NUM)) begin
            if (wr_sel) sh_rst_d[wr_ch] = wr_data;
            else        sh_set_d[wr_ch] = wr_data;
        end
    end

    // Scan FSM: next state, comparator evaluation, pending/overrun tracking.
    always_comb begin
        state_d   = state_q;
        angle_d   = angle_q;
        pending_d = pending_q;
        idx_d     = idx_q;
        ch_out_d  = ch_out_q;
        ovr_set   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ch_out_d  = '0;
                pending_d = '0;
                idx_d     = '0;
                if (hwag_start) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (!hwag_start) begin
                    state_d   = ST_IDLE;
                    ch_out_d  = '0;
                    pending_d = '0;
                    idx_d     = '0;
                end else begin
                    if (pending_q[idx_q]) begin
                        // Reset match takes priority so set==rst keeps the output low.
                        if (angle_q == act_rst_q[idx_q])      ch_out_d[idx_q] = 1'b0;
                        else if (angle_q == act_set_q[idx_q]) ch_out_d[idx_q] = 1'b1;
                        pending_d[idx_q] = 1'b0;
                        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + CH_AW'(1);
                    end
                    // A new tick restarts the scan; channels not yet reached
                    // for the previous angle are dropped.
                    if (angle_tick) begin
                        angle_d   = angle;
                        pending_d = '1;
                        idx_d     = '0;
                        ovr_set   = |pending_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ch_out_d = ch_out_d & ch_ena;
    end

    // Sticky overrun; a new overrun event wins over a clear in the same cycle.
    always_comb begin
        overrun_d = overrun_q;
        if (ovr_set)      overrun_d = 1'b1;
        else if (ovr_clr) overrun_d = 1'b0;
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            angle_q   <= '0;
            pending_q <= '0;
            idx_q     <= '0;
            ch_out_q  <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) begin
                sh_set_q[i]  <= '0;
                sh_rst_q[i]  <= '0;
                act_set_q[i] <= '0;
                act_rst_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            angle_q   <= angle_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            ch_out_q  <= ch_out_d;
            overrun_q <= overrun_d;
            sh_set_q  <= sh_set_d;
            sh_rst_q  <= sh_rst_d;
            act_set_q <= act_set_d;
            act_rst_q <= act_rst_d;
        end
    end

    assign ch_out    = ch_out_q;
    assign scan_busy = |pending_q;
    assign overrun   = overrun_q;

endmodule
